// File: rtl/mc_price_finalizer.sv
// Monte Carlo price finalizer: gates the payoff accumulator, divides sum by path count and presents the price.
// Optional discount stage (SCALE, disc_in latch, multiplier) is compiled in with `define PRICE_DISCOUNT_EN.
module mc_price_finalizer #(
  parameter int unsigned N_PATHS = 32,
  parameter int unsigned FRAC_W  = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go_in,
  input  logic        done_in,
  input  logic [31:0] sum_in,
  input  logic [31:0] count_in,
  input  logic [31:0] disc_in,
  output logic        acc_en_out,
  output logic        busy,
  output logic [31:0] price_out,
  output logic        price_valid,
  input  logic        price_ready,
  output logic        div_zero
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ITER_W = 5;
  localparam int unsigned HI_W   = 2 * DATA_W - FRAC_W;

  if (N_PATHS == 0 || FRAC_W >= DATA_W) begin : g_param_chk
    $error("mc_price_finalizer: N_PATHS must be nonzero and FRAC_W below 32");
  end

  typedef enum logic [2:0] {IDLE, COLLECT, DIVIDE, SCALE, OUTPUT} state_t;

  state_t              state;
  logic [DATA_W-1:0]   quo_q;
  logic [DATA_W-1:0]   div_q;
  logic [DATA_W-1:0]   rem_q;
  logic [ITER_W-1:0]   iter_q;

  logic [DATA_W:0]     rem_shift;
  logic [DATA_W-1:0]   rem_sub;
  logic [DATA_W-1:0]   rem_next;
  logic                rem_ge;
  logic [DATA_W-1:0]   quo_next;
  logic [DATA_W-1:0]   mean_c;
  logic                div_last;

  // One restoring-division step: the dividend shifts out of quo_q MSB first as quotient bits shift in.
  always_comb begin
    rem_shift = {rem_q, quo_q[DATA_W-1]};
    rem_ge    = rem_shift >= {1'b0, div_q};
    rem_sub   = rem_shift[DATA_W-1:0] - div_q;
    rem_next  = rem_ge ? rem_sub : rem_shift[DATA_W-1:0];
    quo_next  = {quo_q[DATA_W-2:0], rem_ge};
    mean_c    = (div_q == '0) ? '0 : quo_next;
    div_last  = (div_q == '0) || (iter_q == ITER_W'(DATA_W - 1));
  end

`ifdef PRICE_DISCOUNT_EN
  logic [DATA_W-1:0] disc_q;
  logic [HI_W-1:0]   prod_hi;
  logic [DATA_W-1:0] scaled;

  // Q8.24 x Q8.24 product realigned to Q8.24; any integer overflow saturates.
  always_comb begin
    prod_hi = HI_W'(({{DATA_W{1'b0}}, quo_q} * {{DATA_W{1'b0}}, disc_q}) >> FRAC_W);
    scaled  = (|prod_hi[HI_W-1:DATA_W]) ? '1 : prod_hi[DATA_W-1:0];
  end
`else
  logic unused_disc;
  assign unused_disc = ^disc_in;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      acc_en_out  <= 1'b0;
      busy        <= 1'b0;
      price_out   <= '0;
      price_valid <= 1'b0;
      div_zero    <= 1'b0;
      quo_q       <= '0;
      div_q       <= '0;
      rem_q       <= '0;
      iter_q      <= '0;
`ifdef PRICE_DISCOUNT_EN
      disc_q      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (go_in) begin
`ifdef PRICE_DISCOUNT_EN
            disc_q <= disc_in;
`endif
            acc_en_out <= 1'b1;
            busy       <= 1'b1;
            state      <= COLLECT;
          end
        end
        COLLECT: begin
          if (done_in) begin
            quo_q      <= sum_in;
            div_q      <= count_in;
            rem_q      <= '0;
            iter_q     <= '0;
            div_zero   <= (count_in == '0);
            acc_en_out <= 1'b0;
            state      <= DIVIDE;
          end
        end
        DIVIDE: begin
          rem_q  <= rem_next;
          quo_q  <= mean_c;
          iter_q <= iter_q + 1'b1;
          if (div_last) begin
`ifdef PRICE_DISCOUNT_EN
            state       <= SCALE;
`else
            price_out   <= mean_c;
            price_valid <= 1'b1;
            state       <= OUTPUT;
`endif
          end
        end
`ifdef PRICE_DISCOUNT_EN
        SCALE: begin
          price_out   <= scaled;
          price_valid <= 1'b1;
          state       <= OUTPUT;
        end
`endif
        OUTPUT: begin
          if (price_ready) begin
            price_valid <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_price_finalizer.sv
// Randomized bench for mc_price_finalizer against an arithmetic price/latency model.
// Follows the PRICE_DISCOUNT_EN setting of the build.
module tb_mc_price_finalizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        go_in;
  logic        done_in;
  logic [31:0] sum_in;
  logic [31:0] count_in;
  logic [31:0] disc_in;
  logic        acc_en_out;
  logic        busy;
  logic [31:0] price_out;
  logic        price_valid;
  logic        price_ready;
  logic        div_zero;

  int n_cmp = 0;
  int n_err = 0;

  mc_price_finalizer dut (
    .clk        (clk),
    .rst        (rst),
    .go_in      (go_in),
    .done_in    (done_in),
    .sum_in     (sum_in),
    .count_in   (count_in),
    .disc_in    (disc_in),
    .acc_en_out (acc_en_out),
    .busy       (busy),
    .price_out  (price_out),
    .price_valid(price_valid),
    .price_ready(price_ready),
    .div_zero   (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Price from the arithmetic definition: floor(sum/count), then Q8.24 discount with saturation.
  function automatic logic [31:0] ref_price(input logic [31:0] sum, input logic [31:0] cnt,
                                            input logic [31:0] disc);
    longint unsigned mean;
    longint unsigned p;
    mean = (cnt == 0) ? 64'd0 : 64'(sum) / 64'(cnt);
`ifdef PRICE_DISCOUNT_EN
    p = (mean * 64'(disc)) >> 24;
`else
    p = mean + 64'(disc & 32'h0);
`endif
    return (p > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : 32'(p);
  endfunction

  // Edges after the capture edge until price_valid is seen high.
  function automatic int ref_latency(input logic [31:0] cnt);
    int lat;
    lat = (cnt == 0) ? 1 : 32;
`ifdef PRICE_DISCOUNT_EN
    lat = lat + 1;
`endif
    return lat;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_acc_en"}, 32'(acc_en_out), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_valid"}, 32'(price_valid), 32'd0);
    check({tag, "_div_zero"}, 32'(div_zero), 32'd0);
    check({tag, "_price"}, price_out, 32'd0);
  endtask

  task automatic start_and_capture(input logic [31:0] sum, input logic [31:0] cnt,
                                   input logic [31:0] disc, input bit ready_early);
    disc_in = disc;
    go_in   = 1'b1;
    tick();
    go_in   = 1'b0;
    check("acc_en_collect", 32'(acc_en_out), 32'd1);
    check("busy_collect", 32'(busy), 32'd1);
    repeat ($urandom_range(0, 3)) begin
      tick();
      check("acc_en_wait", 32'(acc_en_out), 32'd1);
    end
    sum_in      = sum;
    count_in    = cnt;
    done_in     = 1'b1;
    price_ready = ready_early;
    tick();
    done_in  = 1'b0;
    sum_in   = $urandom;
    count_in = $urandom;
    disc_in  = $urandom;
  endtask

  task automatic run_price(input logic [31:0] sum, input logic [31:0] cnt, input logic [31:0] disc,
                           input int bp_cycles, input bit ready_early);
    logic [31:0] exp_p;
    logic [31:0] held;
    int lat;
    exp_p = ref_price(sum, cnt, disc);
    start_and_capture(sum, cnt, disc, ready_early);
    lat = 0;
    while (!price_valid && lat < 60) begin
      check("acc_en_low", 32'(acc_en_out), 32'd0);
      go_in   = 1'($urandom_range(0, 1));
      done_in = 1'($urandom_range(0, 1));
      tick();
      lat++;
    end
    go_in   = 1'b0;
    done_in = 1'b0;
    check("latency", 32'(lat), 32'(ref_latency(cnt)));
    check("price", price_out, exp_p);
    check("div_zero", 32'(div_zero), 32'(cnt == 0));
    check("busy_output", 32'(busy), 32'd1);
    held = price_out;
    if (!ready_early) begin
      repeat (bp_cycles) begin
        tick();
        check("valid_hold", 32'(price_valid), 32'd1);
        check("price_hold", price_out, held);
      end
      price_ready = 1'b1;
    end
    tick();
    price_ready = 1'b0;
    check("valid_fall", 32'(price_valid), 32'd0);
    check("busy_fall", 32'(busy), 32'd0);
    check("acc_en_idle", 32'(acc_en_out), 32'd0);
    check("price_keep", price_out, exp_p);
  endtask

  // Assert reset at capture edge + rst_edge and expect a clean idle block.
  task automatic reset_mid(input logic [31:0] cnt, input int rst_edge, input bit expect_valid);
    start_and_capture(32'h1000_0000, cnt, 32'h00F5_C28F, 1'b0);
    repeat (rst_edge - 1) tick();
    check("pre_reset_valid", 32'(price_valid), 32'(expect_valid));
    rst = 1'b0;
    tick();
    check_reset_state("mid_reset");
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] s;
    logic [31:0] c;
    logic [31:0] d;
    rst         = 1'b0;
    go_in       = 1'b0;
    done_in     = 1'b0;
    sum_in      = '0;
    count_in    = '0;
    disc_in     = '0;
    price_ready = 1'b0;
    tick();
    tick();
    check_reset_state("reset");
    rst = 1'b1;
    tick();

    run_price(32'h1000_0000, 32'd32, 32'h00F5_C28F, 10, 1'b0);
    run_price(32'h0100_0000, 32'd0,  32'h00F5_C28F, 2,  1'b0);
    run_price(32'hFF00_0000, 32'd1,  32'h0200_0000, 1,  1'b0);
    run_price(32'h1234_5678, 32'd7,  32'h0100_0000, 0,  1'b1);

    reset_mid(32'd32, 10, 1'b0);
    run_price(32'h1000_0000, 32'd32, 32'h00F5_C28F, 0, 1'b0);
    reset_mid(32'd0, 10, 1'b1);
    run_price(32'h1000_0000, 32'd32, 32'h00F5_C28F, 3, 1'b1);

    for (int i = 0; i < 24; i++) begin
      s = $urandom;
      case ($urandom_range(0, 3))
        0:       c = 32'd0;
        1:       c = 32'($urandom_range(1, 64));
        2:       c = $urandom;
        default: c = 32'd32;
      endcase
      d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 32'h0300_0000));
      run_price(s, c, d, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mc_price_finalizer.md
# mc_price_finalizer

Downstream stage of the Monte Carlo payoff accumulator in the Heston pricer. Gates the accumulator's enable, waits for its completion flag, captures the payoff sum and path count, and computes the mean payoff with a 32-cycle sequential restoring divider. Optionally scales the mean by a discount factor, then presents the option price on a valid/ready output handshake.

## Interface
Parameters:
- `N_PATHS`, default 32: path count the accumulator reports at completion. Informational; the block computes with `count_in` as received.
- `FRAC_W`, default 24: fraction bits of the Q8.24 data format.

Ports:
- `clk`, input, 1: the single clock; all logic is rising-edge.
- `rst`, input, 1: synchronous, active-low reset.
- `go_in`, input, 1: start a pricing run; sampled only in IDLE.
- `done_in`, input, 1: accumulator completion flag.
- `sum_in`, input, 32: accumulated payoff sum, unsigned Q8.24.
- `count_in`, input, 32: accumulated path count, unsigned integer.
- `disc_in`, input, 32: discount factor exp(-rT), unsigned Q8.24; sampled at capture.
- `acc_en_out`, output, 1: accumulator enable; low clears the accumulator.
- `busy`, output, 1: high in every state except IDLE.
- `price_out`, output, 32: option price, unsigned Q8.24.
- `price_valid`, output, 1: `price_out` is valid.
- `price_ready`, input, 1: consumer accepts the price.
- `div_zero`, output, 1: the last capture saw `count_in == 0`.

## Operation
States are IDLE, COLLECT, DIVIDE, SCALE and OUTPUT.

- **IDLE**: `acc_en_out` is 0. If `go_in` is 1, latch `disc_in` and go to COLLECT.
- **COLLECT**: `acc_en_out` is 1. When `done_in` is 1, capture `sum_in` and `count_in`, drive `acc_en_out` to 0 on the next cycle, and go to DIVIDE.
- **DIVIDE**: 32 iterations of restoring division, one quotient bit per cycle, MSB first.
  - mean = floor(sum / count). The result stays in Q8.24 because count is an integer. The remainder is discarded.
  - count == 0: skip the iterations, set mean to 0, set `div_zero` to 1, and go directly to SCALE.
- **SCALE**: form the 64-bit product mean × disc and take bits [55:24], truncating.
  - If any of bits [63:56] is nonzero, saturate the result to 0xFFFFFFFF.
- **OUTPUT**: load `price_out` and hold `price_valid` at 1 until a cycle with `price_ready` = 1. Then go to IDLE.

Rules that apply in every state:
- `price_out` is held stable while `price_valid` is 1.
- `price_out` keeps its last value after the handshake.
- `div_zero` holds until the next capture, which rewrites it.
- `go_in` is ignored outside IDLE.
- `done_in` is ignored outside COLLECT.

## Timing
Reset (`rst` = 0 at a rising edge):
- State returns to IDLE.
- `acc_en_out`, `busy`, `price_valid` and `div_zero` are 0.
- `price_out` is 0x00000000.
- All internal divider registers are cleared.
- Reset takes effect from any state, including mid-DIVIDE and during OUTPUT backpressure. No partial result is ever presented.

Latency and handshake:
- Edge C is the edge at which COLLECT samples `done_in` = 1.
- DIVIDE occupies the 32 edges C+1 through C+32.
- SCALE completes at edge C+33.
- `price_valid` rises after edge C+33 with the discount stage compiled in (see Configuration).
- With count == 0, `price_valid` rises after edge C+2.
- The handshake completes on the first edge where `price_valid` and `price_ready` are both 1.
- `price_valid` falls after that edge. Return to IDLE and `busy` falling happen on the same edge.
- A new `go_in` is accepted on the following edge at the earliest.
- `price_ready` may be high before `price_valid`. The handshake then completes on the first valid cycle.

## Configuration
`PRICE_DISCOUNT_EN`:
- **Defined**: the SCALE state, the `disc_in` latch and the multiplier exist. Price = mean × disc.
- **Undefined**: SCALE is removed and `disc_in` is ignored.
  - Price = mean, unscaled. DIVIDE goes directly to OUTPUT.
  - `price_valid` rises one cycle earlier: after edge C+32, or after C+1 for count == 0.

## Test plan
- **Nominal, macro defined**: `go_in`, then `done_in` with sum 0x10000000, count 32 and disc 0x00F5C28F. Required: `price_out` = 0x007AE147, `price_valid` after edge C+33, `div_zero` = 0.
- **Nominal, macro undefined**: the same stimulus. Required: `price_out` = 0x00800000, `price_valid` after edge C+32.
- **Zero count**: `done_in` with count 0 and sum 0x01000000. Required: `div_zero` = 1, `price_out` = 0x00000000, `price_valid` after edge C+2 (macro defined).
- **Saturation**: sum 0xFF000000, count 1, disc 0x02000000. Required: `price_out` = 0xFFFFFFFF.
- **Backpressure and enable**: hold `price_ready` low for 10 cycles after `price_valid`. Required:
  - `price_valid` stays 1 and `price_out` is unchanged.
  - The handshake completes on the first cycle `price_ready` is high, and `busy` is 0 on the next cycle.
  - `acc_en_out` is 1 only during COLLECT.
- **Reset mid-divide**: drive `rst` = 0 at edge C+10. Required:
  - All outputs are 0 on the next cycle and the state is IDLE.
  - A subsequent nominal run produces 0x007AE147 with the standard latency.
